muller_c_formal: RTL and testbench

Clocked, formally checkable model of a bank of Muller C-elements for the muller_c_proj user project.
- Three 2-input C-elements sample pairs of bits from io_in[5:0].
- A 3-input C-element merges the three stage outputs.
- An embedded protocol monitor flags illegal output behaviour and records sticky cover events.
- Used as the formal/cover target and as the synchronous (async2sync) equivalent of the asynchronous project.

---
 rtl/muller_c_formal_if.sv | 16 +
 rtl/muller_c_formal.sv | 83 ++++++++
 tb/tb_muller_c_formal.sv | 112 +++++++++++
 3 files changed

// File: rtl/muller_c_formal_if.sv
// Stimulus/observation bundle for the clocked Muller C-element bank.
// The master side drives io_in; the slave side (the design) returns state and monitor flags.
interface muller_c_formal_if #(
  parameter int WIDTH = 6
);
  localparam int NP = WIDTH / 2;

  logic [WIDTH-1:0] io_in;
  logic [NP-1:0]    c_out;
  logic             c_all;
  logic             err;
  logic [3:0]       cov;

  modport master (output io_in, input c_out, input c_all, input err, input cov);
  modport slave  (input io_in, output c_out, output c_all, output err, output cov);
endinterface

// File: rtl/muller_c_formal.sv
// Clocked bank of 2-input Muller C-elements merged by a WIDTH/2-input C-element,
// with an embedded protocol monitor (sticky err) and sticky cover flags.
module muller_c_formal #(
  parameter int   WIDTH     = 6,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  muller_c_formal_if.slave   bus
);
  localparam int NP = WIDTH / 2;

  function automatic logic c_elem2(input logic a, input logic b, input logic c);
    return (a & b) | (c & (a | b));
  endfunction

  function automatic logic c_merge(input logic [NP-1:0] v, input logic c);
    return (&v) | (c & (|v));
  endfunction

  logic [NP-1:0]    c_q, c_d;
  logic             call_q, call_d;
  logic [WIDTH-1:0] pio_q;
  logic [NP-1:0]    pc_q;
  logic             pca_q;
  logic             vld_q;
  logic [NP-1:0]    risen_q, risen_d;
  logic             err_q, err_d;
  logic [3:0]       cov_q, cov_d;
  logic             viol_s;

  // Next state of the C-elements and the monitor/cover flags.
  always_comb begin
    c_d     = c_q;
    viol_s  = 1'b0;
    for (int k = 0; k < NP; k++) begin
      c_d[k] = c_elem2(bus.io_in[2*k], bus.io_in[2*k+1], c_q[k]);
      // A disagreeing pair must hold; an agreeing pair must drive the state to its value.
      viol_s = viol_s
             | ((pio_q[2*k] ^ pio_q[2*k+1]) & (c_q[k] ^ pc_q[k]))
             | (~(pio_q[2*k] ^ pio_q[2*k+1]) & (pio_q[2*k] ^ pc_q[k]) & ~(c_q[k] ^ pc_q[k]));
    end
    call_d  = c_merge(c_q, call_q);
    viol_s  = viol_s | ((call_q ^ pca_q) & ~(&pc_q) & (|pc_q));
    err_d   = err_q | (vld_q & viol_s);
    risen_d = risen_q | (c_d & ~c_q);
    cov_d   = cov_q;
    cov_d[0] = cov_q[0] | (|(c_d & ~c_q));
    cov_d[1] = cov_q[1] | (|(c_q & ~c_d & risen_q));
    cov_d[2] = cov_q[2] | (call_d & ~call_q);
    cov_d[3] = cov_q[3] | (~call_d & call_q);
  end

  // State, history and sticky flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q     <= {NP{RESET_VAL}};
      call_q  <= RESET_VAL;
      pio_q   <= {WIDTH{1'b0}};
      pc_q    <= {NP{RESET_VAL}};
      pca_q   <= RESET_VAL;
      vld_q   <= 1'b0;
      risen_q <= {NP{1'b0}};
      err_q   <= 1'b0;
      cov_q   <= 4'b0000;
    end else begin
      c_q     <= c_d;
      call_q  <= call_d;
      pio_q   <= bus.io_in;
      pc_q    <= c_q;
      pca_q   <= call_q;
      vld_q   <= 1'b1;
      risen_q <= risen_d;
      err_q   <= err_d;
      cov_q   <= cov_d;
    end
  end

  assign bus.c_out = c_q;
  assign bus.c_all = call_q;
  assign bus.err   = err_q;
  assign bus.cov   = cov_q;
endmodule

// File: tb/tb_muller_c_formal.sv
// Directed, table-driven bench for muller_c_formal plus hand-written reset sequences.
module tb_muller_c_formal;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  muller_c_formal_if #(.WIDTH(6)) bus ();

  muller_c_formal #(.WIDTH(6), .RESET_VAL(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] io;
    logic [2:0] c;
    logic       all;
    logic [3:0] cov;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] c, input logic all,
                         input logic e, input logic [3:0] cv);
    chk({tag, ".c_out"}, {5'b00000, bus.c_out}, {5'b00000, c});
    chk({tag, ".c_all"}, {7'b0000000, bus.c_all}, {7'b0000000, all});
    chk({tag, ".err"},   {7'b0000000, bus.err},   {7'b0000000, e});
    chk({tag, ".cov"},   {4'b0000, bus.cov},      {4'b0000, cv});
  endtask

  function automatic vec_t mk(input logic [5:0] io, input logic [2:0] c,
                              input logic all, input logic [3:0] cov);
    vec_t v;
    v.io = io; v.c = c; v.all = all; v.cov = cov;
    return v;
  endfunction

  initial begin
    checks = 0;
    errors = 0;

    // Expected values after one rising edge with the given io_in applied.
    vecs.push_back(mk(6'b000101, 3'b000, 1'b0, 4'b0000));
    vecs.push_back(mk(6'b000101, 3'b000, 1'b0, 4'b0000));
    vecs.push_back(mk(6'b000101, 3'b000, 1'b0, 4'b0000));
    vecs.push_back(mk(6'b111111, 3'b111, 1'b0, 4'b0001));
    vecs.push_back(mk(6'b111111, 3'b111, 1'b1, 4'b0101));
    vecs.push_back(mk(6'b010101, 3'b111, 1'b1, 4'b0101));
    vecs.push_back(mk(6'b010101, 3'b111, 1'b1, 4'b0101));
    vecs.push_back(mk(6'b010101, 3'b111, 1'b1, 4'b0101));
    vecs.push_back(mk(6'b000000, 3'b000, 1'b1, 4'b0111));
    vecs.push_back(mk(6'b000000, 3'b000, 1'b0, 4'b1111));
    vecs.push_back(mk(6'b000011, 3'b001, 1'b0, 4'b1111));
    vecs.push_back(mk(6'b000011, 3'b001, 1'b0, 4'b1111));
    vecs.push_back(mk(6'b000110, 3'b001, 1'b0, 4'b1111));
    vecs.push_back(mk(6'b001100, 3'b010, 1'b0, 4'b1111));
    vecs.push_back(mk(6'b101010, 3'b010, 1'b0, 4'b1111));
    vecs.push_back(mk(6'b111111, 3'b111, 1'b0, 4'b1111));
    vecs.push_back(mk(6'b111111, 3'b111, 1'b1, 4'b1111));

    rst_n     = 1'b0;
    bus.io_in = 6'b000101;
    #1;
    chk_all("reset0", 3'b000, 1'b0, 1'b0, 4'b0000);
    @(posedge clk);
    @(negedge clk);
    chk_all("reset_held", 3'b000, 1'b0, 1'b0, 4'b0000);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      bus.io_in = vecs[i].io;
      @(posedge clk);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vecs[i].c, vecs[i].all, 1'b0, vecs[i].cov);
    end

    // Mid-cycle async reset with c_out=111 clears everything without an edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 3'b000, 1'b0, 1'b0, 4'b0000);
    bus.io_in = 6'b111111;
    @(posedge clk);
    @(negedge clk);
    chk_all("rst_low_edge", 3'b000, 1'b0, 1'b0, 4'b0000);
    rst_n = 1'b1;
    #1;
    chk_all("release_no_edge", 3'b000, 1'b0, 1'b0, 4'b0000);
    @(posedge clk);
    @(negedge clk);
    chk_all("post_release1", 3'b111, 1'b0, 1'b0, 4'b0001);
    @(posedge clk);
    @(negedge clk);
    chk_all("post_release2", 3'b111, 1'b1, 1'b0, 4'b0101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
